// File: rtl/zxw_lab9_read.sv
// Read-side sequencer: walks all 2^ADDR_W RAM words from a start address, showing each for DWELL
// cycles. Optional build macro ZXW_READ_CHECKSUM_EN shows a modulo-256 word sum after the pass.
module zxw_lab9_read #(
    parameter int unsigned ADDR_W = 5,
    parameter int unsigned DATA_W = 8,
    parameter int unsigned DWELL  = 4
) (
    input  logic              Clock,
    input  logic              Reset,
    input  logic [ADDR_W-1:0] SW_in,
    input  logic              Start,
    output logic [ADDR_W-1:0] Mem_addr,
    output logic              Mem_rden,
    input  logic [DATA_W-1:0] Mem_q,
    output logic [DATA_W-1:0] Display_out,
    output logic              Busy,
    output logic              Done
);

    localparam logic [ADDR_W-1:0] CntLast   = '1;
    localparam logic [7:0]        DwellInit = 8'(DWELL - 1);

    typedef enum logic [2:0] {StIdle, StRead, StWait, StShow, StDone} state_e;

    state_e              state_q, state_d;
    logic [ADDR_W-1:0]   addr_q;
    logic [ADDR_W-1:0]   cnt_q;
    logic [7:0]          dwell_q;
    logic [DATA_W-1:0]   disp_q;
`ifdef ZXW_READ_CHECKSUM_EN
    logic [7:0]          sum_q;
`endif

    always_ff @(posedge Clock) begin
        if (Reset) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            StIdle:  if (Start) state_d = StRead;
            StRead:  state_d = StWait;
            StWait:  state_d = StShow;
            StShow: begin
                if (dwell_q == 8'd0) begin
                    state_d = (cnt_q == CntLast) ? StDone : StRead;
                end
            end
            StDone:  state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    always_comb begin
        Mem_rden = (state_q == StRead);
        Busy     = (state_q != StIdle);
        Done     = (state_q == StDone);
    end

    always_ff @(posedge Clock) begin
        if (Reset) begin
            addr_q  <= '0;
            cnt_q   <= '0;
            dwell_q <= 8'd0;
            disp_q  <= '0;
`ifdef ZXW_READ_CHECKSUM_EN
            sum_q   <= 8'd0;
`endif
        end else begin
            case (state_q)
                StIdle: begin
                    if (Start) begin
                        addr_q <= SW_in;
                        cnt_q  <= '0;
`ifdef ZXW_READ_CHECKSUM_EN
                        sum_q  <= 8'd0;
`endif
                    end
                end
                StWait: begin
                    // Registered RAM: data for the READ address is on Mem_q this cycle.
                    disp_q  <= Mem_q;
                    dwell_q <= DwellInit;
`ifdef ZXW_READ_CHECKSUM_EN
                    sum_q   <= sum_q + 8'(Mem_q);
`endif
                end
                StShow: begin
                    if (dwell_q != 8'd0) begin
                        dwell_q <= dwell_q - 8'd1;
                    end else if (cnt_q == CntLast) begin
`ifdef ZXW_READ_CHECKSUM_EN
                        disp_q <= DATA_W'(sum_q);
`endif
                    end else begin
                        addr_q <= addr_q + 1'b1;
                        cnt_q  <= cnt_q + 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    assign Mem_addr    = addr_q;
    assign Display_out = disp_q;

endmodule

// File: tb/tb_zxw_lab9_read.sv
// Directed bench for zxw_lab9_read: table of read passes plus hand-written reset/start corner cases.
module tb_zxw_lab9_read;

    localparam int unsigned Dwell = 4;

    logic       clock = 1'b0;
    logic       reset;
    logic [4:0] sw_in;
    logic       start;
    logic [4:0] mem_addr;
    logic       mem_rden;
    logic [7:0] mem_q;
    logic [7:0] display_out;
    logic       busy;
    logic       done;

    logic [7:0] ram [32];
    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [4:0] sw;
        int         restart_word;
        int         reset_word;
        bit         done_start;
    } vec_t;

    vec_t vecs [5];

    zxw_lab9_read #(.ADDR_W(5), .DATA_W(8), .DWELL(Dwell)) dut (
        .Clock      (clock),
        .Reset      (reset),
        .SW_in      (sw_in),
        .Start      (start),
        .Mem_addr   (mem_addr),
        .Mem_rden   (mem_rden),
        .Mem_q      (mem_q),
        .Display_out(display_out),
        .Busy       (busy),
        .Done       (done)
    );

    always #5 clock = ~clock;

    always @(posedge clock) if (mem_rden) mem_q <= ram[mem_addr];

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [7:0] final_val(input logic [4:0] sw);
        logic [7:0] s;
        logic [4:0] last;
        s = 8'd0;
        for (int i = 0; i < 32; i++) s = s + ram[i];
        last = sw - 5'd1;
`ifdef ZXW_READ_CHECKSUM_EN
        return s;
`else
        return ram[last];
`endif
    endfunction

    task automatic check_idle(input string tag, input logic [7:0] disp);
        check({tag, "_busy"}, busy, 0);
        check({tag, "_rden"}, mem_rden, 0);
        check({tag, "_done"}, done, 0);
        check({tag, "_disp"}, display_out, disp);
    endtask

    // Caller is at a negedge; Start is raised immediately.
    task automatic run_pass(input vec_t v);
        logic [4:0] a;
        logic [7:0] fin;
        fin = final_val(v.sw);
        sw_in = v.sw;
        start = 1'b1;
        for (int k = 0; k < 32; k++) begin
            a = v.sw + 5'(k);
            @(negedge clock);
            start = 1'b0;
            check("read_rden", mem_rden, 1);
            check("read_addr", mem_addr, a);
            check("read_busy", busy, 1);
            @(negedge clock);
            check("wait_rden", mem_rden, 0);
            check("wait_done", done, 0);
            if (k == v.restart_word) begin
                start = 1'b1;
                sw_in = 5'd5;
            end
            for (int d = 0; d < Dwell; d++) begin
                @(negedge clock);
                start = 1'b0;
                check("show_disp", display_out, ram[a]);
                check("show_busy", busy, 1);
                check("show_done", done, 0);
                if (k == v.reset_word && d == 0) begin
                    reset = 1'b1;
                    @(negedge clock);
                    reset = 1'b0;
                    check_idle("rst_mid", 8'h00);
                    check("rst_mid_addr", mem_addr, 0);
                    for (int c = 0; c < 40; c++) begin
                        @(negedge clock);
                        check_idle("rst_after", 8'h00);
                    end
                    return;
                end
            end
        end
        @(negedge clock);
        check("done_pulse", done, 1);
        check("done_busy", busy, 1);
        check("done_disp", display_out, fin);
        if (v.done_start) begin
            start = 1'b1;
            sw_in = 5'd9;
        end
        @(negedge clock);
        start = 1'b0;
        check_idle("post_done", fin);
    endtask

    initial begin
        for (int i = 0; i < 32; i++) ram[i] = 8'h10 + 8'(i);
        vecs[0] = '{sw: 5'd0,  restart_word: -1, reset_word: -1, done_start: 1'b0};
        vecs[1] = '{sw: 5'd30, restart_word: -1, reset_word: -1, done_start: 1'b1};
        vecs[2] = '{sw: 5'd0,  restart_word: 3,  reset_word: -1, done_start: 1'b0};
        vecs[3] = '{sw: 5'd7,  restart_word: -1, reset_word: 10, done_start: 1'b0};
        vecs[4] = '{sw: 5'd12, restart_word: -1, reset_word: -1, done_start: 1'b0};

        // Reset held with Start high: Reset must win.
        reset = 1'b1;
        start = 1'b1;
        sw_in = 5'd17;
        repeat (10) begin
            @(negedge clock);
            check_idle("rst_hold", 8'h00);
        end
        reset = 1'b0;
        start = 1'b0;
        for (int c = 0; c < 20; c++) begin
            @(negedge clock);
            check_idle("rst_idle", 8'h00);
            check("rst_idle_addr", mem_addr, 0);
        end

        for (int i = 0; i < 5; i++) run_pass(vecs[i]);

        // Simultaneous Reset and Start from IDLE.
        reset = 1'b1;
        start = 1'b1;
        sw_in = 5'd21;
        @(negedge clock);
        reset = 1'b0;
        start = 1'b0;
        check_idle("rst_start", 8'h00);
        check("rst_start_addr", mem_addr, 0);
        @(negedge clock);
        check_idle("rst_start2", 8'h00);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/zxw_lab9_read.md
# zxw_lab9_read

Read-side sequencer for the lab 9 memory path: on a `Start` pulse it reads every word of the 32×8 on-chip RAM, beginning at the address on `SW_in` and wrapping. It presents each word on `Display_out` for a programmable dwell time, then pulses `Done`. It sits between the lab 9 writer-filled RAM (its read port) and the board display. It is the reader counterpart to the lab 9 write logic.

## Interface
Parameters:
- `ADDR_W`, 5, RAM address width; word count is 2^ADDR_W.
- `DATA_W`, 8, RAM data and display width.
- `DWELL`, 4, number of cycles each word is held in SHOW; legal range 1..255.

Ports:
- `Clock`  in  1  single system clock; all state updates on its rising edge.
- `Reset`  in  1  synchronous, active-high reset.
- `SW_in`  in  ADDR_W  start address; sampled only on an accepted `Start`.
- `Start`  in  1  one-cycle request to begin a read pass.
- `Mem_addr`  out  ADDR_W  RAM read address.
- `Mem_rden`  out  1  RAM read enable.
- `Mem_q`  in  DATA_W  RAM read data; registered RAM, valid 1 cycle after the `Mem_rden` edge.
- `Display_out`  out  DATA_W  currently displayed word.
- `Busy`  out  1  high in every state except IDLE.
- `Done`  out  1  one-cycle pulse at the end of a pass.

## Operation
States: IDLE, READ, WAIT, SHOW, DONE. State is encoded in registers. `Mem_rden`, `Busy` and `Done` decode combinationally from state.
- IDLE: `Mem_rden`=0 and `Busy`=0.
  - `Start`=1 latches addr←`SW_in`, cnt←0, then goes to READ.
  - `Display_out` holds its last value.
- READ: `Mem_rden`=1 and `Mem_addr`=addr. Goes to WAIT.
- WAIT: `Mem_q` is valid this cycle. At the edge: `Display_out`←`Mem_q`, dwell←DWELL−1, then goes to SHOW.
- SHOW: `Display_out` is held.
  - If dwell≠0: dwell←dwell−1.
  - Otherwise, if cnt=2^ADDR_W−1: go to DONE.
  - Otherwise: addr←addr+1 (modulo 2^ADDR_W, so 31→0 wraps), cnt←cnt+1, go to READ.
- DONE: `Done`=1 for exactly this cycle. Goes to IDLE.
- Arithmetic rules:
  - addr is ADDR_W bits and wraps naturally.
  - cnt is ADDR_W bits and counts 0..31.
  - dwell is 8 bits.
- `Start` while `Busy`=1 is ignored. It does not restart the pass and does not re-sample `SW_in`.
- `Mem_addr` always drives the addr register, including in IDLE.

## Timing
- Reset values: state=IDLE, `Display_out`=0x00, `Mem_addr`=0, `Mem_rden`=0, `Busy`=0, `Done`=0, cnt=0, dwell=0.
- `Reset` overrides everything, including mid-pass. The next cycle is IDLE with all outputs at reset values, and no `Done` pulse is issued.
- `Start` accepted at edge t:
  - READ during cycle t+1.
  - The first word appears on `Display_out` after edge t+2.
- Each word occupies DWELL+2 cycles: READ, WAIT, then SHOW×DWELL.
- With `Start` accepted at edge t, the full pass is 32·(DWELL+2) cycles and `Done` is high in cycle t+1+32·(DWELL+2).
- `Start` asserted in the DONE cycle is ignored. `Start` asserted in the cycle after DONE (IDLE) is accepted.
- Simultaneous `Reset` and `Start`: `Reset` wins.

## Configuration
- `ZXW_READ_CHECKSUM_EN` defined:
  - An 8-bit sum register is cleared on an accepted `Start`.
  - It accumulates `Mem_q` (modulo 256) in each WAIT cycle.
  - On the transition SHOW→DONE, `Display_out`←sum, so the checksum is shown in DONE and held through IDLE.
- Not defined: no sum register. `Display_out` keeps the last word (RAM[start−1 mod 32]) after the pass.
- Interface and cycle timing are identical in both builds.

## Test plan
- Reset hold for 10 cycles, then release with `Start`=0 → `Display_out`=0x00, `Busy`=0, `Mem_rden`=0, and no state change for 20 cycles.
- RAM[i]=i+0x10, `SW_in`=0, DWELL=4, `Start` pulse → `Display_out` steps 0x10, 0x11, …, 0x2F, each held 4 cycles, 6 cycles apart. `Done` rises exactly 192 cycles after the READ cycle of word 0.
- `SW_in`=30, same RAM → display order 0x2E, 0x2F, 0x10, 0x11, …, 0x2D (wrap 31→0). `Mem_addr` sequence is 30, 31, 0, ….
- `Start` pulsed again with `SW_in`=5 during word 3 → sequence continues unchanged and `Done` timing is unchanged.
- `Reset` asserted for 1 cycle mid-pass (SHOW of word 10) → next cycle IDLE, `Display_out`=0x00, no `Done`. A new `Start` then restarts cleanly from `SW_in`.
- With `ZXW_READ_CHECKSUM_EN`, RAM[i]=i+0x10 → `Display_out`=0xF0 in the DONE cycle and thereafter. Without the macro → `Display_out`=0x2F.
